// File: rtl/tawas_au_seq_pkg.sv
// Shared constants, op/state encodings and slot payload for the long-op sequencer.
package tawas_au_seq_pkg;

  localparam int unsigned NTHREADS = 4;
  localparam int unsigned THREAD_W = 2;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned CNT_W    = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } req_t;

  function automatic logic is_div(input op_e op);
    return (op == OP_DIVQ) || (op == OP_DIVR);
  endfunction

endpackage

// File: rtl/tawas_au_seq_if.sv
// Request, flush and writeback bundle between the AU decoder and the long-op sequencer.
interface tawas_au_seq_if;
  import tawas_au_seq_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [THREAD_W-1:0] req_thread;
  logic [1:0]          req_op;
  logic [REG_W-1:0]    req_reg;
  logic [XLEN-1:0]     req_a;
  logic [XLEN-1:0]     req_b;
  logic                flush_en;
  logic [THREAD_W-1:0] flush_thread;
  logic [NTHREADS-1:0] thread_busy;
  logic                wb_valid;
  logic                wb_ready;
  logic [THREAD_W-1:0] wb_thread;
  logic [REG_W-1:0]    wb_reg;
  logic [XLEN-1:0]     wb_data;

  modport master (
    output req_valid, req_thread, req_op, req_reg, req_a, req_b,
    output flush_en, flush_thread, wb_ready,
    input  req_ready, thread_busy, wb_valid, wb_thread, wb_reg, wb_data
  );

  modport slave (
    input  req_valid, req_thread, req_op, req_reg, req_a, req_b,
    input  flush_en, flush_thread, wb_ready,
    output req_ready, thread_busy, wb_valid, wb_thread, wb_reg, wb_data
  );

endinterface

// File: rtl/tawas_au_seq_rr.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap, first requester wins.
module tawas_au_seq_rr
  import tawas_au_seq_pkg::*;
(
  input  logic [NTHREADS-1:0] req,
  input  logic [THREAD_W-1:0] ptr,
  output logic [NTHREADS-1:0] gnt_oh,
  output logic [THREAD_W-1:0] gnt_idx
);

  logic                found;
  logic [THREAD_W-1:0] idx;

  // Priority rotates so the thread just after the last winner is checked first.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= int'(NTHREADS); i++) begin
      idx = THREAD_W'((int'(ptr) + i) % int'(NTHREADS));
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt_oh[idx]  = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/tawas_au_seq.sv
// Per-thread pending slots feeding one shared iterative 32-bit mul/div engine.
module tawas_au_seq
  import tawas_au_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  tawas_au_seq_if.slave bus
);

  state_e              state_q, state_d;
  logic [NTHREADS-1:0] slot_valid_q, slot_valid_d;
  req_t                slot_q [NTHREADS];
  req_t                slot_d [NTHREADS];
  logic [THREAD_W-1:0] ptr_q, ptr_d;
  logic [THREAD_W-1:0] cur_thread_q, cur_thread_d;
  op_e                 cur_op_q, cur_op_d;
  logic [REG_W-1:0]    cur_reg_q, cur_reg_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wb_valid_q, wb_valid_d;
  logic [THREAD_W-1:0] wb_thread_q, wb_thread_d;
  logic [REG_W-1:0]    wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;

  logic [NTHREADS-1:0] flush_mask, arb_req, gnt_oh;
  logic [THREAD_W-1:0] gnt_idx;
  logic                gnt_any, accept, wb_hs, flush_cur, div_ge;
  req_t                gnt_req;
  logic [XLEN:0]       mul_sum, div_shift;
  logic [XLEN-1:0]     result;

  assign bus.req_ready   = !slot_valid_q[bus.req_thread];
  assign bus.thread_busy = slot_valid_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_thread   = wb_thread_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_data     = wb_data_q;

  assign accept     = bus.req_valid && bus.req_ready;
  assign wb_hs      = wb_valid_q && bus.wb_ready;
  assign flush_cur  = bus.flush_en && (state_q != IDLE) && (bus.flush_thread == cur_thread_q);
  assign flush_mask = bus.flush_en ? (NTHREADS'(1) << bus.flush_thread) : '0;
  // A thread being flushed this cycle must not be started.
  assign arb_req    = slot_valid_q & ~flush_mask;
  assign gnt_any    = |gnt_oh;
  assign gnt_req    = slot_q[gnt_idx];

  tawas_au_seq_rr u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // One iteration step: shift-add multiply, restoring divide.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};

  // Low half holds product-lo / quotient, high half product-hi / remainder.
  always_comb begin
    case (cur_op_q)
      OP_MULLO, OP_DIVQ: result = lo_q;
      default:           result = hi_q;
    endcase
  end

  // Slot bookkeeping and engine sequencing.
  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    ptr_d        = ptr_q;
    cur_thread_d = cur_thread_q;
    cur_op_d     = cur_op_q;
    cur_reg_d    = cur_reg_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opnd_d       = opnd_q;
    cnt_d        = cnt_q;
    wb_valid_d   = wb_valid_q;
    wb_thread_d  = wb_thread_q;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;

    // Commit, then flush, then capture the new request.
    if (wb_hs)        slot_valid_d[cur_thread_q]     = 1'b0;
    if (bus.flush_en) slot_valid_d[bus.flush_thread] = 1'b0;
    if (accept) begin
      slot_valid_d[bus.req_thread] = 1'b1;
      slot_d[bus.req_thread] = '{op: op_e'(bus.req_op), rd: bus.req_reg,
                                 a: bus.req_a, b: bus.req_b};
    end

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ptr_d        = gnt_idx;
          cur_thread_d = gnt_idx;
          cur_op_d     = gnt_req.op;
          cur_reg_d    = gnt_req.rd;
          cnt_d        = '0;
          state_d      = RUN;
          if (is_div(gnt_req.op)) begin
            hi_d   = '0;
            lo_d   = gnt_req.a;
            opnd_d = gnt_req.b;
            // Divide by zero skips the iterations: quotient all ones, remainder = dividend.
            if (gnt_req.b == '0) begin
              hi_d    = gnt_req.a;
              lo_d    = '1;
              state_d = DONE;
            end
          end else begin
            hi_d   = '0;
            lo_d   = gnt_req.b;
            opnd_d = gnt_req.a;
          end
        end
      end
      RUN: begin
        if (is_div(cur_op_q)) begin
          hi_d = div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = DONE;
      end
      DONE: begin
        if (!wb_valid_q) begin
          wb_valid_d  = 1'b1;
          wb_thread_d = cur_thread_q;
          wb_reg_d    = cur_reg_q;
          wb_data_d   = result;
        end else if (bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Killing the in-flight thread abandons the engine without a writeback.
    if (flush_cur) begin
      state_d    = IDLE;
      wb_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_valid_q <= '0;
      for (int i = 0; i < int'(NTHREADS); i++) slot_q[i] <= '0;
      ptr_q        <= THREAD_W'(NTHREADS - 1);
      cur_thread_q <= '0;
      cur_op_q     <= OP_MULLO;
      cur_reg_q    <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opnd_q       <= '0;
      cnt_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_thread_q  <= '0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      ptr_q        <= ptr_d;
      cur_thread_q <= cur_thread_d;
      cur_op_q     <= cur_op_d;
      cur_reg_q    <= cur_reg_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      opnd_q       <= opnd_d;
      cnt_q        <= cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_thread_q  <= wb_thread_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_tawas_au_seq.sv
// Bench for the long-op sequencer: directed cases plus random traffic against a thread-level model.
module tb_tawas_au_seq;
  import tawas_au_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  tawas_au_seq_if bus ();

  tawas_au_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which threads hold an op, and what each must write back.
  logic [NTHREADS-1:0] pend;
  logic [NTHREADS-1:0] pend0;
  logic [XLEN-1:0]     exp_data [NTHREADS];
  logic [REG_W-1:0]    exp_reg  [NTHREADS];
  int                  wb_order [$];
  int                  mt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (op)
      2'd0:    return p[XLEN-1:0];
      2'd1:    return p[2*XLEN-1:XLEN];
      2'd2:    return (b == '0) ? '1 : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Observe each cycle mid-period; handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = '0;
    end else begin
      pend0 = pend;
      check("busy", 64'(bus.thread_busy), 64'(pend0));
      check("req_ready", 64'(bus.req_ready), 64'(!pend0[bus.req_thread]));
      if (bus.wb_valid && bus.wb_ready) begin
        mt = int'(bus.wb_thread);
        check("wb_pending", 64'(pend0[mt]), 64'(1));
        check("wb_data", 64'(bus.wb_data), 64'(exp_data[mt]));
        check("wb_reg", 64'(bus.wb_reg), 64'(exp_reg[mt]));
        wb_order.push_back(mt);
        pend[mt] = 1'b0;
      end
      if (bus.flush_en) pend[bus.flush_thread] = 1'b0;
      if (bus.req_valid && !pend0[bus.req_thread]) begin
        mt = int'(bus.req_thread);
        pend[mt]     = 1'b1;
        exp_data[mt] = ref_result(bus.req_op, bus.req_a, bus.req_b);
        exp_reg[mt]  = bus.req_reg;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int t, input logic [1:0] op, input int rd,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int n;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_thread = THREAD_W'(t);
    bus.req_op     = op;
    bus.req_reg    = REG_W'(rd);
    bus.req_a      = a;
    bus.req_b      = b;
    #1;
    while (!bus.req_ready && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (!bus.req_ready) check("issue_timeout", 64'(bus.req_ready), 64'(1));
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wb(output int cyc);
    cyc = 0;
    while (!bus.wb_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!bus.wb_valid) check("wb_timeout", 64'(bus.wb_valid), 64'(1));
  endtask

  task automatic run_op(input int t, input logic [1:0] op, input int rd,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat);
    int cyc;
    bus.wb_ready = 1'b1;
    issue(t, op, rd, a, b);
    wait_wb(cyc);
    check("latency", 64'(cyc), 64'(lat));
    check("data", 64'(bus.wb_data), 64'(exp));
    check("thread", 64'(bus.wb_thread), 64'(t));
    check("reg", 64'(bus.wb_reg), 64'(rd));
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    bus.flush_en  = 1'b0;
    bus.wb_ready  = 1'b1;
    while (pend != '0 && n < 2000) begin
      tick();
      n++;
    end
    tick();
    check("drain_busy", 64'(bus.thread_busy), 64'(0));
  endtask

  initial begin
    int cyc;
    int cnt;
    int r;
    pend = '0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_thread   = '0;
    bus.req_op       = '0;
    bus.req_reg      = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.flush_en     = 1'b0;
    bus.flush_thread = '0;
    bus.wb_ready     = 1'b1;
    repeat (3) tick();
    check("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("rst_wb_thread", 64'(bus.wb_thread), 64'(0));
    check("rst_wb_reg", 64'(bus.wb_reg), 64'(0));
    check("rst_wb_data", 64'(bus.wb_data), 64'(0));
    check("rst_busy", 64'(bus.thread_busy), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // Directed arithmetic and latency cases.
    run_op(1, 2'b01, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN + 2);
    run_op(2, 2'b10, 1, 32'd100, 32'd7, 32'd14, XLEN + 2);
    run_op(2, 2'b11, 1, 32'd100, 32'd7, 32'd2, XLEN + 2);
    run_op(2, 2'b00, 4, 32'h1_0000, 32'h1_0000, 32'd0, XLEN + 2);
    run_op(0, 2'b10, 6, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2);
    run_op(0, 2'b11, 6, 32'h1234, 32'd0, 32'h1234, 2);

    // All threads queue up; round-robin returns them in thread order.
    wb_order.delete();
    for (int t = 0; t < int'(NTHREADS); t++) issue(t, 2'b00, t + 1, 32'(t + 3), 32'd9);
    drain();
    check("rr_count", 64'(wb_order.size()), 64'(NTHREADS));
    for (int i = 0; i < wb_order.size(); i++) check("rr_order", 64'(wb_order[i]), 64'(i));

    // Backpressure holds DONE; release lets the next thread start the following cycle.
    bus.wb_ready = 1'b0;
    issue(0, 2'b00, 3, 32'd3, 32'd5);
    issue(1, 2'b01, 2, 32'h8000_0000, 32'd4);
    wait_wb(cyc);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(bus.wb_valid), 64'(1));
      check("hold_data", 64'(bus.wb_data), 64'(15));
      check("hold_thread", 64'(bus.wb_thread), 64'(0));
      check("hold_reg", 64'(bus.wb_reg), 64'(3));
      check("hold_busy", 64'(bus.thread_busy), 64'(4'b0011));
      tick();
    end
    bus.wb_ready = 1'b1;
    tick();
    wait_wb(cyc);
    check("next_grant_latency", 64'(cyc), 64'(XLEN + 2));
    check("next_data", 64'(bus.wb_data), 64'(2));
    tick();

    // Flush of the in-flight thread at iteration 10.
    issue(3, 2'b00, 7, 32'd1000, 32'd1000);
    repeat (11) tick();
    bus.flush_en     = 1'b1;
    bus.flush_thread = 2'd3;
    tick();
    bus.flush_en = 1'b0;
    check("flush_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("flush_busy3", 64'(bus.thread_busy[3]), 64'(0));
    run_op(2, 2'b00, 1, 32'd6, 32'd7, 32'd42, XLEN + 2);

    // Random traffic with backpressure, flushes and zero divisors.
    for (int c = 0; c < 1500; c++) begin
      bus.req_valid    = ($urandom_range(0, 1) == 1);
      bus.req_thread   = THREAD_W'($urandom_range(0, NTHREADS - 1));
      bus.req_op       = 2'($urandom_range(0, 3));
      bus.req_reg      = REG_W'($urandom_range(0, 7));
      r                = int'($urandom_range(0, 7));
      bus.req_a        = (r == 2) ? 32'($urandom_range(0, 255)) : $urandom;
      bus.req_b        = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      bus.flush_en     = ($urandom_range(0, 15) == 0);
      bus.flush_thread = THREAD_W'($urandom_range(0, NTHREADS - 1));
      bus.wb_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset in the middle of a multiply clears everything at once.
    issue(1, 2'b00, 2, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("mid_rst_busy", 64'(bus.thread_busy), 64'(0));
    check("mid_rst_wb_data", 64'(bus.wb_data), 64'(0));
    check("mid_rst_wb_reg", 64'(bus.wb_reg), 64'(0));
    check("mid_rst_wb_thread", 64'(bus.wb_thread), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.wb_valid) cnt++;
    end
    check("post_rst_no_wb", 64'(cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
